// File: rtl/neuron_operand_feeder.sv
// Collects 4 signed activations, then issues the vector to N_NEURONS neurons, one per cycle, each with its weight set.
// Optional macro FEEDER_ZERO_SKIP_EN: suppress input_ready on issue cycles whose 4 weights are all zero.
module neuron_operand_feeder #(
  parameter  int IN_W      = 5,
  parameter  int W_W       = 5,
  parameter  int N_NEURONS = 4,
  localparam int AW        = $clog2(N_NEURONS * 4),
  localparam int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [IN_W-1:0] s_data,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic signed [W_W-1:0]  cfg_wdata,
  output logic                   input_ready,
  output logic signed [IN_W-1:0] in0,
  output logic signed [IN_W-1:0] in1,
  output logic signed [IN_W-1:0] in2,
  output logic signed [IN_W-1:0] in3,
  output logic signed [W_W-1:0]  w0,
  output logic signed [W_W-1:0]  w1,
  output logic signed [W_W-1:0]  w2,
  output logic signed [W_W-1:0]  w3,
  output logic [IDX_W-1:0]       issue_idx,
  output logic                   vec_done
);

  localparam logic [0:0]       ST_COLLECT = 1'b0;
  localparam logic [0:0]       ST_ISSUE   = 1'b1;
  localparam int               BANK_N     = N_NEURONS * 4;
  localparam logic [AW:0]      BANK_LIM   = (AW + 1)'(BANK_N);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_NEURONS - 1);

  logic [0:0]             r_state;
  logic [1:0]             r_elem_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic signed [IN_W-1:0] r_vec  [4];
  logic signed [W_W-1:0]  r_bank [BANK_N];

  logic                   w_issue;
  logic                   w_cfg_hit;
  logic signed [W_W-1:0]  w_wsel [4];

  assign w_issue   = (r_state == ST_ISSUE);
  assign w_cfg_hit = cfg_we && ({1'b0, cfg_addr} < BANK_LIM);

  // Bank row select: neuron index in the upper bits, weight pair k in the low two.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_wsel[k] = r_bank[AW'({r_idx, 2'(k)})];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_COLLECT;
      r_elem_cnt <= '0;
      r_idx      <= '0;
      for (int k = 0; k < 4; k++) begin
        r_vec[k] <= '0;
      end
      for (int a = 0; a < BANK_N; a++) begin
        r_bank[a] <= '0;
      end
    end else begin
      if (w_cfg_hit) begin
        r_bank[cfg_addr] <= cfg_wdata;
      end
      case (r_state)
        ST_COLLECT: begin
          if (flush) begin
            r_elem_cnt <= '0;
          end else if (s_valid) begin
            r_vec[r_elem_cnt] <= s_data;
            if (r_elem_cnt == 2'd3) begin
              r_elem_cnt <= '0;
              r_idx      <= '0;
              r_state    <= ST_ISSUE;
            end else begin
              r_elem_cnt <= r_elem_cnt + 2'd1;
            end
          end
        end
        default: begin
          if (flush || (r_idx == LAST_IDX)) begin
            r_idx   <= '0;
            r_state <= ST_COLLECT;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
      endcase
    end
  end

  // Operands are held at zero outside ISSUE so the neuron inputs never toggle idly.
  assign s_ready   = (r_state == ST_COLLECT);
  assign in0       = w_issue ? r_vec[0] : '0;
  assign in1       = w_issue ? r_vec[1] : '0;
  assign in2       = w_issue ? r_vec[2] : '0;
  assign in3       = w_issue ? r_vec[3] : '0;
  assign w0        = w_issue ? w_wsel[0] : '0;
  assign w1        = w_issue ? w_wsel[1] : '0;
  assign w2        = w_issue ? w_wsel[2] : '0;
  assign w3        = w_issue ? w_wsel[3] : '0;
  assign issue_idx = w_issue ? r_idx : '0;
  assign vec_done  = w_issue && (r_idx == LAST_IDX);

`ifdef FEEDER_ZERO_SKIP_EN
  logic w_nz;
  assign w_nz        = (w_wsel[0] != '0) || (w_wsel[1] != '0) ||
                       (w_wsel[2] != '0) || (w_wsel[3] != '0);
  assign input_ready = w_issue && w_nz;
`else
  assign input_ready = w_issue;
`endif

endmodule

// File: tb/tb_neuron_operand_feeder.sv
// Directed and random bench for neuron_operand_feeder against a queue-based operand schedule model.
module tb_neuron_operand_feeder;
  localparam int IN_W  = 5;
  localparam int W_W   = 5;
  localparam int N     = 4;
  localparam int AW    = 4;
  localparam int IDX_W = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  logic                   s_valid = 1'b0;
  logic signed [IN_W-1:0] s_data = '0;
  logic                   cfg_we = 1'b0;
  logic [AW-1:0]          cfg_addr = '0;
  logic signed [W_W-1:0]  cfg_wdata = '0;
  logic                   s_ready, input_ready, vec_done;
  logic signed [IN_W-1:0] in0, in1, in2, in3;
  logic signed [W_W-1:0]  w0, w1, w2, w3;
  logic [IDX_W-1:0]       issue_idx;

  neuron_operand_feeder #(.IN_W(IN_W), .W_W(W_W), .N_NEURONS(N)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .input_ready(input_ready), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3), .issue_idx(issue_idx), .vec_done(vec_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: either gathering activations into a queue, or walking through the neurons.
  bit m_collect;
  int m_elems[$];
  int m_vec[4];
  int m_idx;
  int m_bank[N*4];

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_collect = 1'b1;
    m_elems.delete();
    m_idx = 0;
    for (int k = 0; k < 4; k++) m_vec[k] = 0;
    for (int a = 0; a < N*4; a++) m_bank[a] = 0;
  endtask

  task automatic check_outputs();
    bit iss;
    int eir;
    int ew[4];
    iss = !m_collect;
    for (int k = 0; k < 4; k++) ew[k] = iss ? m_bank[m_idx*4 + k] : 0;
    eir = iss ? 1 : 0;
`ifdef FEEDER_ZERO_SKIP_EN
    if (iss && ew[0] == 0 && ew[1] == 0 && ew[2] == 0 && ew[3] == 0) eir = 0;
`endif
    chk("s_ready", int'(s_ready), iss ? 0 : 1);
    chk("input_ready", int'(input_ready), eir);
    chk("in0", int'(in0), iss ? m_vec[0] : 0);
    chk("in1", int'(in1), iss ? m_vec[1] : 0);
    chk("in2", int'(in2), iss ? m_vec[2] : 0);
    chk("in3", int'(in3), iss ? m_vec[3] : 0);
    chk("w0", int'(w0), ew[0]);
    chk("w1", int'(w1), ew[1]);
    chk("w2", int'(w2), ew[2]);
    chk("w3", int'(w3), ew[3]);
    chk("issue_idx", int'(issue_idx), iss ? m_idx : 0);
    chk("vec_done", int'(vec_done), (iss && m_idx == N - 1) ? 1 : 0);
  endtask

  task automatic model_update();
    if (m_collect) begin
      if (flush) begin
        m_elems.delete();
      end else if (s_valid) begin
        m_elems.push_back(int'(s_data));
        if (m_elems.size() == 4) begin
          for (int k = 0; k < 4; k++) m_vec[k] = m_elems[k];
          m_elems.delete();
          m_collect = 1'b0;
          m_idx = 0;
        end
      end
    end else begin
      if (flush || m_idx == N - 1) m_collect = 1'b1;
      else m_idx++;
    end
    if (cfg_we && int'(cfg_addr) < N*4) m_bank[cfg_addr] = int'(cfg_wdata);
  endtask

  task automatic tick();
    check_outputs();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    s_valid = 1'b0;
    flush   = 1'b0;
    cfg_we  = 1'b0;
  endtask

  task automatic send(int v, bit fl);
    s_valid = 1'b1;
    s_data  = IN_W'(v);
    flush   = fl;
    tick();
    idle();
  endtask

  task automatic wr(int a, int d);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(a);
    cfg_wdata = W_W'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Neuron n gets weight n+1 on every pair.
    for (int n = 0; n < N; n++)
      for (int k = 0; k < 4; k++) wr(n*4 + k, n + 1);

    send(1, 0); send(2, 0); send(-3, 0); send(15, 0);
    repeat (N + 1) tick();

    // Continuous s_valid: three back-to-back vectors plus slack.
    s_valid = 1'b1;
    for (int c = 0; c < 26; c++) begin
      s_data = IN_W'($urandom);
      tick();
    end
    idle();
    repeat (2) tick();

    // Write bank[1*4+2] while neuron 1 issues; new value appears on the next vector.
    send(3, 0); send(-4, 0); send(5, 0); send(-6, 0);
    tick();
    wr(1*4 + 2, -16);
    repeat (3) tick();
    send(7, 0); send(8, 0); send(-9, 0); send(10, 0);
    repeat (N + 1) tick();

    // Flush alongside the 2nd element, then a fresh vector.
    send(11, 0); send(12, 1);
    send(-1, 0); send(-2, 0); send(-5, 0); send(-7, 0);
    // Flush while neuron 1 issues.
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();

    // Neuron 2 all-zero weights.
    for (int k = 0; k < 4; k++) wr(2*4 + k, 0);
    send(4, 0); send(4, 0); send(-4, 0); send(-16, 0);
    repeat (N + 1) tick();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      s_valid   = ($urandom_range(0, 3) != 0);
      s_data    = IN_W'($urandom);
      flush     = ($urandom_range(0, 19) == 0);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = AW'($urandom);
      cfg_wdata = W_W'($urandom);
      tick();
    end
    idle();
    repeat (N + 2) tick();

    // Reset in the middle of issuing neuron 2.
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    send(-8, 0); send(9, 0); send(-10, 0); send(6, 0);
    repeat (N + 1) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
